// File: rtl/coeff_load_controller.sv
// Coefficient bank loader: streams BITS-wide taps into an addressed register bank,
// zero-fills the unused taps and commits the tap-enable mask in a single edge.
module coeff_load_controller #(
  parameter int BITS = 32,
  parameter int CGES = 49,
  parameter int AW   = $clog2(CGES),
  parameter int NW   = $clog2(CGES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NW-1:0]   tap_num,
  input  logic            abort,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITS-1:0] s_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [BITS-1:0] wr_data,
  output logic [CGES-1:1] cges,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      state_dbg
);

  // Handshake: a beat transfers on a rising edge where s_valid && s_ready.
  // s_ready is only high in LOAD and is dropped combinationally by abort,
  // so an abort always wins over a coincident beat.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [NW-1:0]   n_q, n_nxt;
  logic [AW-1:0]   idx_q, idx_nxt;
  logic            wr_en_q, wr_en_nxt;
  logic [AW-1:0]   wr_addr_q, wr_addr_nxt;
  logic [BITS-1:0] wr_data_q, wr_data_nxt;
  logic [CGES-1:1] cges_q, cges_nxt;
  logic            done_q, done_nxt;
  logic            err_q, err_nxt;
  logic            s_ready_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cges_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      n_q       <= n_nxt;
      idx_q     <= idx_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
      cges_q    <= cges_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    n_nxt       = n_q;
    idx_nxt     = idx_q;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    cges_nxt    = cges_q;
    done_nxt    = 1'b0;
    err_nxt     = err_q;
    s_ready_c   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (tap_num != '0 && tap_num <= NW'(CGES)) begin
            n_nxt     = tap_num;
            idx_nxt   = '0;
            err_nxt   = 1'b0;
            state_nxt = LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        s_ready_c = !abort;
        if (abort) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (s_valid) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = idx_q;
          wr_data_nxt = s_data;
          idx_nxt     = idx_q + AW'(1);
          if (NW'(idx_q) == n_q - NW'(1)) begin
            state_nxt = (n_q == NW'(CGES)) ? COMMIT : FILL;
          end
        end
      end
      FILL: begin
        // idx continues from n, so the fill covers exactly n..CGES-1
        if (abort) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = idx_q;
          wr_data_nxt = '0;
          idx_nxt     = idx_q + AW'(1);
          if (idx_q == AW'(CGES - 1)) begin
            state_nxt = COMMIT;
          end
        end
      end
      COMMIT: begin
        for (int i = 1; i < CGES; i++) begin
          cges_nxt[i] = (NW'(i) < n_q);
        end
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_ready   = s_ready_c;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cges      = cges_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_coeff_load_controller.sv
// Directed bench for coeff_load_controller: write stream scoreboard, mask commit,
// latency, error/abort handling and asynchronous reset.
module tb_coeff_load_controller;

  localparam int BITS = 32;
  localparam int CGES = 49;
  localparam int AW   = 6;
  localparam int NW   = 6;
  localparam int W    = AW + BITS;

  logic            clk;
  logic            reset;
  logic            start;
  logic [NW-1:0]   tap_num;
  logic            abort;
  logic            s_valid;
  logic            s_ready;
  logic [BITS-1:0] s_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [BITS-1:0] wr_data;
  logic [CGES-1:1] cges;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t0 = 0;
  int done_at = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  coeff_load_controller #(.BITS(BITS), .CGES(CGES)) dut (
    .clk(clk), .reset(reset), .start(start), .tap_num(tap_num), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cges(cges),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // scoreboard: every bank write must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      checks++;
      if (exp_q.size() != 0) exp_w = exp_q.pop_front();
      else exp_w = 'x;
      assert ({wr_addr, wr_data} === exp_w) else begin
        errors++;
        $error("FAIL wr_beat: got addr %0d data %0h, expected addr/data %0h", wr_addr, wr_data, exp_w);
      end
    end
    if (!reset && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_wr(input int addr, input logic [BITS-1:0] data);
    exp_q.push_back({AW'(addr), data});
  endtask

  task automatic start_session(input int t);
    start   = 1'b1;
    tap_num = NW'(t);
    @(posedge clk); #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  // drive n beats; toggle inserts a bubble every other cycle; abort_at >= 0
  // raises abort together with s_valid once that many beats have transferred
  task automatic feed(input int n, input bit toggle, input logic [BITS-1:0] base, input int abort_at);
    int  beats;
    bit  phase;
    bit  acc;
    beats = 0;
    phase = 1'b1;
    for (int k = 0; k < 4 * n + 10 && beats < n; k++) begin
      s_data = base + BITS'(beats);
      if (beats == abort_at) begin
        abort   = 1'b1;
        s_valid = 1'b1;
        #1;
        check("abort_s_ready", s_ready, 0);
        @(posedge clk); #1;
        abort   = 1'b0;
        s_valid = 1'b0;
        return;
      end
      s_valid = toggle ? phase : 1'b1;
      #1;
      check("load_s_ready", s_ready, 1);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) beats++;
      phase = !phase;
    end
    s_valid = 1'b0;
    check("feed_beats", beats, n);
  endtask

  task automatic wait_done(input logic [CGES-1:1] old_mask);
    bit moved;
    bit seen;
    moved = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen    = 1'b1;
        done_at = cyc;
      end else if (cges !== old_mask) begin
        moved = 1'b1;
      end
    end
    check("done_seen", seen, 1);
    check("mask_stable", moved, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tap_num = '0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    #2;
    check("rst_wr_en", wr_en, 0);
    check("rst_cges", cges, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // full-length load, no stalls: writes 0..48 / 1..49, done 50 edges after start
    for (int i = 0; i < CGES; i++) push_wr(i, BITS'(i + 1));
    start_session(49);
    check("t2_busy", busy, 1);
    feed(49, 1'b0, 32'd1, -1);
    wait_done(48'h0);
    check("t2_latency", done_at - t0, 50);
    check("t2_cges", cges, 48'hFFFF_FFFF_FFFF);
    check("t2_q_empty", exp_q.size(), 0);
    check("t2_done_cnt", done_cnt, 1);

    // short load with bubbles; the rest of the bank is zero-filled
    for (int i = 0; i < 5; i++) push_wr(i, 32'hA + BITS'(i));
    for (int i = 5; i < CGES; i++) push_wr(i, 32'h0);
    start_session(5);
    feed(5, 1'b1, 32'hA, -1);
    wait_done(48'hFFFF_FFFF_FFFF);
    check("t3_cges", cges, 48'h0000_0000_000F); // cges[4:1] set, i.e. 0x1E in absolute bits
    check("t3_q_empty", exp_q.size(), 0);
    check("t3_done_cnt", done_cnt, 2);

    // illegal tap counts
    start_session(0);
    check("t4a_err", err, 1);
    check("t4a_busy", busy, 0);
    start_session(50);
    check("t4b_err", err, 1);
    check("t4b_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_cges", cges, 48'h0000_0000_000F);
    check("t4_done_cnt", done_cnt, 2);

    // abort after three beats, coincident with a valid beat
    for (int i = 0; i < 3; i++) push_wr(i, 32'h100 + BITS'(i));
    start_session(10);
    check("t5_err_cleared", err, 0);
    feed(10, 1'b0, 32'h100, 3);
    check("t5_busy", busy, 0);
    check("t5_err", err, 1);
    check("t5_wr_en", wr_en, 0);
    check("t5_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_cges", cges, 48'h0000_0000_000F);
    check("t5_done_cnt", done_cnt, 2);
    check("t5_q_empty", exp_q.size(), 0);

    // start while busy with another tap count is ignored
    for (int i = 0; i < 3; i++) push_wr(i, 32'h21 + BITS'(i));
    for (int i = 3; i < CGES; i++) push_wr(i, 32'h0);
    start_session(3);
    check("t6_err_cleared", err, 0);
    start   = 1'b1;
    tap_num = NW'(7);
    feed(3, 1'b0, 32'h21, -1);
    start = 1'b0;
    wait_done(48'h0000_0000_000F);
    check("t6_latency", done_at - t0, 50);
    check("t6_cges", cges, 48'h0000_0000_0003);
    check("t6_q_empty", exp_q.size(), 0);
    check("t6_done_cnt", done_cnt, 3);

    // asynchronous reset in the middle of a session
    start_session(10);
    @(posedge clk); #1;
    check("t1_busy_before", busy, 1);
    check("t1_state_before", state_dbg, 2'd1);
    #3 reset = 1'b1;
    #1;
    check("t1_wr_en", wr_en, 0);
    check("t1_wr_addr", wr_addr, 0);
    check("t1_wr_data", wr_data, 0);
    check("t1_cges", cges, 0);
    check("t1_busy", busy, 0);
    check("t1_s_ready", s_ready, 0);
    check("t1_done", done, 0);
    check("t1_err", err, 0);
    check("t1_state", state_dbg, 2'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
